// File: rtl/mips_pkg.sv
// Shared types and constants for the CPU data-port to wait-state RAM bridge.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } bridge_state_t;

    localparam logic [31:0] TIMEOUT_DATA    = 32'hFFFF_FFFF;
    localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/data_mem_bridge_if.sv
// Waitrequest-style data RAM bus between the bridge (master) and the RAM (slave).
interface data_mem_bridge_if;

    // Handshake: read/write, address and writedata are held stable while
    // waitrequest is high; a transfer completes in the cycle a strobe is high
    // and waitrequest is low, and readdata is valid only in that cycle.
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata,
        output waitrequest, readdata
    );

endinterface

// File: rtl/data_mem_bridge_wait_counter.sv
// Saturating waitrequest counter with a terminal flag one short of the timeout.
module wait_counter #(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/data_mem_bridge.sv
// Latches a CPU load/store, runs it on the waitrequest RAM bus and stalls the CPU
// until completion; the CPU's clk_enable is driven from !cpu_stall at the top level.
module data_mem_bridge
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          cpu_address,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic [31:0]          cpu_writedata,
    output logic [31:0]          cpu_readdata,
    output logic                 cpu_stall,
    data_mem_bridge_if.master    mem,
    output logic                 err_flag,
    output logic [CNT_W-1:0]     last_wait_cycles,
    output bridge_state_t        state
);

    logic             op_valid;
    logic             aligned;
    logic             req_ok;
    logic             req_bad;
    logic             cnt_clear;
    logic             cnt_enable;
    logic [CNT_W-1:0] wait_count;
    logic             wait_terminal;

    assign op_valid = cpu_read ^ cpu_write;
    assign aligned  = (cpu_address[1:0] & WORD_ALIGN_MASK) == 2'b00;
    assign req_ok   = op_valid && aligned;
    // Any attempted op that is not a clean aligned single op is flagged, never issued.
    assign req_bad  = (cpu_read || cpu_write) && !req_ok;

    assign cnt_clear  = (state == IDLE);
    assign cnt_enable = (state == ISSUE) && mem.waitrequest;

    wait_counter #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .count    (wait_count),
        .terminal (wait_terminal)
    );

    // Stall is combinational in IDLE so the CPU holds the instruction in the detect cycle.
    always_comb begin
        cpu_stall = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    cpu_stall = req_ok;
                ISSUE:   cpu_stall = 1'b1;
                default: cpu_stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            mem.read         <= 1'b0;
            mem.write        <= 1'b0;
            mem.address      <= '0;
            mem.writedata    <= '0;
            cpu_readdata     <= '0;
            err_flag         <= 1'b0;
            last_wait_cycles <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_ok) begin
                        mem.address   <= {cpu_address[31:2], 2'b00};
                        mem.writedata <= cpu_writedata;
                        mem.read      <= cpu_read;
                        mem.write     <= cpu_write;
                        state         <= ISSUE;
                    end else if (req_bad) begin
                        err_flag     <= 1'b1;
                        cpu_readdata <= '0;
                    end
                end
                ISSUE: begin
                    if (!mem.waitrequest) begin
                        if (mem.read) begin
                            cpu_readdata <= mem.readdata;
                        end
                        mem.read         <= 1'b0;
                        mem.write        <= 1'b0;
                        last_wait_cycles <= wait_count;
                        state            <= DONE;
                    end else if (wait_terminal) begin
                        mem.read         <= 1'b0;
                        mem.write        <= 1'b0;
                        cpu_readdata     <= TIMEOUT_DATA;
                        err_flag         <= 1'b1;
                        last_wait_cycles <= CNT_W'(TIMEOUT_CYCLES);
                        state            <= DONE;
                    end
                end
                // The request still visible in DONE is the retiring instruction; ignore it.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/data_mem_bridge.md
Name: data_mem_bridge

Overview:
Sits between the CPU's combinational data port and a wait-state data RAM on a waitrequest-style bus. Latches each CPU load/store and issues it to memory. Holds the CPU stalled through its clk_enable input until memory completes, then returns read data for exactly one completion cycle. Also flags misaligned, illegal and timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 16, max consecutive mem_waitrequest cycles before an access is aborted (1..255)
CNT_W, 8, width of the wait counter and of last_wait_cycles

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
cpu_address  input  32  byte address from CPU data port
cpu_read  input  1  CPU load request (level)
cpu_write  input  1  CPU store request (level)
cpu_writedata  input  32  store data
cpu_readdata  output  32  load data to CPU
cpu_stall  output  1  high = CPU must hold; top level drives CPU clk_enable = !cpu_stall
mem_address  output  32  word-aligned address to RAM
mem_read  output  1  RAM read strobe
mem_write  output  1  RAM write strobe
mem_writedata  output  32  RAM write data
mem_waitrequest  input  1  RAM not ready; strobes/address/data held while high
mem_readdata  input  32  RAM data, valid in the cycle mem_waitrequest is low with mem_read high
err_flag  output  1  sticky error indicator
last_wait_cycles  output  CNT_W  waitrequest cycles counted on the most recent completed access

Behaviour:
- FSM states: IDLE, ISSUE, DONE.
- Reset values: state=IDLE, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, cpu_readdata=0, err_flag=0, last_wait_cycles=0, wait counter=0.
- While reset is high, cpu_stall is forced 0 combinationally.

IDLE:
- A request is cpu_read^cpu_write, with cpu_address[1:0]==0.
- cpu_stall = 1 combinationally in the same cycle the request is seen, so the CPU does not retire the instruction.
- At the edge: latch address, writedata and op; clear the counter; go to ISSUE.
- Misaligned address (addr[1:0]!=0), or cpu_read&cpu_write both high:
  - no memory access, cpu_stall=0, cpu_readdata=0;
  - err_flag set at the edge; stay in IDLE.
- No request: cpu_stall=0.

ISSUE:
- Registered mem_read/mem_write=1 and mem_address/mem_writedata driven from latched values, held stable; cpu_stall=1.
- If mem_waitrequest is low: capture mem_readdata into cpu_readdata (reads only); last_wait_cycles <= counter; go to DONE.
- Else counter += 1.
- If the counter reaches TIMEOUT_CYCLES-1 with waitrequest still high:
  - abort: strobes drop next cycle; cpu_readdata <= 32'hFFFF_FFFF; err_flag set; last_wait_cycles <= TIMEOUT_CYCLES; go to DONE.
- Strobes are high exactly one cycle when waitrequest is already low (zero-wait access = 1 ISSUE cycle).

DONE:
- cpu_stall=0 and strobes low; cpu_readdata holds the captured value; the CPU retires the instruction at this edge.
- Unconditional transition to IDLE. The request still presented in this cycle is the same instruction and must not be re-issued.
- cpu_readdata holds until the next capture.

Latency and ordering:
- Total CPU stall for an aligned access = 1 (IDLE detect) + ISSUE cycles; N waitrequest cycles give N+2 stalled cycles including the IDLE-detect cycle.
- Writes complete identically, with no readdata update (cpu_readdata is unchanged).
- err_flag is cleared only by reset.
- The counter saturates; no wrap.

Reset mid-operation: at the reset edge the FSM goes to IDLE and strobes drop the next cycle. The in-flight access is abandoned, with no completion and no error.

Decomposition:
- Shared package mips_pkg holds:
  - state typedef bridge_state_t {IDLE, ISSUE, DONE};
  - constant TIMEOUT_DATA = 32'hFFFF_FFFF;
  - constant WORD_ALIGN_MASK = 2'b11.
- One sub-module: wait_counter (clear, enable, saturating CNT_W count, terminal-count compare against TIMEOUT_CYCLES-1).
- The FSM, the request latch and the output registers stay in data_mem_bridge.
- Top level wires mips_cpu_harvard.clk_enable = !cpu_stall.

Test Plan:
1. Read at 0x100, mem_waitrequest=0, mem_readdata=0x12345678. Required: cpu_stall high 2 cycles, mem_read high 1 cycle at address 0x100, cpu_readdata=0x12345678 in DONE, last_wait_cycles=0, err_flag=0.
2. Write 0xCAFEF00D to 0x200 with waitrequest high 3 cycles. Required: mem_write, address and data stable for 4 cycles; cpu_stall high 5 cycles; last_wait_cycles=3; cpu_readdata unchanged.
3. Read at 0x103. Required: no mem strobe, cpu_stall=0, cpu_readdata=0, err_flag=1 after the edge and still 1 after 10 idle cycles.
4. Read with waitrequest held high, TIMEOUT_CYCLES=16. Required: after 16 ISSUE cycles mem_read drops, cpu_readdata=0xFFFFFFFF, err_flag=1, last_wait_cycles=16, FSM returns to IDLE.
5. Back-to-back reads at 0x0 then 0x4 (request held through DONE). Required: exactly two mem_read bursts, no duplicate issue for the first address in its DONE cycle.
6. Reset asserted on the 2nd ISSUE cycle of a waiting read. Required: next cycle mem_read=0, cpu_stall=0, err_flag=0, cpu_readdata=0; a subsequent read completes normally.
